// File: rtl/fir_stream_engine_pkg.sv
// Shared types and helpers for the FIR stream engine: mode and FSM state
// encodings plus a constant-evaluable ceil(log2) used for widths.
package fir_stream_engine_pkg;

    typedef enum logic [1:0] {
        MODE_FIR     = 2'b00,
        MODE_BYPASS  = 2'b01,
        MODE_MUTE    = 2'b10,
        MODE_FIR_ALT = 2'b11
    } mode_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_FETCH = 3'd2,
        ST_MAC   = 3'd3,
        ST_WRITE = 3'd4
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    function automatic logic mode_is_fir(input mode_t m);
        return (m == MODE_FIR) || (m == MODE_FIR_ALT);
    endfunction

endpackage

// File: rtl/fir_stream_engine_fifo.sv
// Synchronous first-word-fall-through FIFO; pointers carry one extra wrap bit
// so full/empty are distinguished without a separate counter.
module fir_stream_engine_fifo
    import fir_stream_engine_pkg::*;
#(
    parameter int W     = 16,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr;
    logic [AW:0]  rptr;
    logic         do_push;
    logic         do_pop;

    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty   = (wptr == rptr);
    // A push on a full FIFO is dropped even when a pop happens in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = empty ? '0 : mem[rptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/fir_stream_engine.sv
// Streaming FIR stage: input FIFO -> sequential one-tap-per-cycle MAC with
// saturation (or bypass/mute) -> output FIFO, with runtime coefficient load.
module fir_stream_engine
    import fir_stream_engine_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int COEF_W    = 16,
    parameter int TAPS      = 8,
    parameter int IN_DEPTH  = 8,
    parameter int OUT_DEPTH = 8,
    parameter int SHIFT     = 15
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_put,
    input  logic              req_put,
    output logic              full_to_bus,
    output logic [DATA_W-1:0] data_to_bus,
    output logic              empty_to_bus,
    input  logic              req_get_frombus,
    input  logic [1:0]        mode,
    input  logic              start_coe,
    input  logic [COEF_W-1:0] coe_data,
    input  logic              coe_valid,
    output logic              busy,
    output logic              sat_flag
);

    localparam int ACC_W  = DATA_W + COEF_W + clog2(TAPS);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int IDX_W  = (clog2(TAPS) > 0) ? clog2(TAPS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TAPS - 1);
    localparam logic signed [ACC_W-1:0] SAT_HI =
        {{(ACC_W - DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_LO =
        {{(ACC_W - DATA_W + 1){1'b1}}, {(DATA_W - 1){1'b0}}};

    function automatic logic sat_over(input logic signed [ACC_W-1:0] v);
        return (v > SAT_HI) || (v < SAT_LO);
    endfunction

    function automatic logic signed [DATA_W-1:0] saturate(input logic signed [ACC_W-1:0] v);
        if (v > SAT_HI)      return SAT_HI[DATA_W-1:0];
        else if (v < SAT_LO) return SAT_LO[DATA_W-1:0];
        else                 return v[DATA_W-1:0];
    endfunction

    state_t                    state;
    logic                      load_pend;
    logic [IDX_W-1:0]          idx;
    logic signed [COEF_W-1:0]  coef  [TAPS];
    logic signed [DATA_W-1:0]  dline [TAPS];
    mode_t                     mode_p0;
    logic signed [DATA_W-1:0]  smp_p0;
    logic signed [ACC_W-1:0]   acc_p1;
    logic signed [ACC_W-1:0]   acc_shr;
    logic signed [PROD_W-1:0]  prod;
    logic signed [DATA_W-1:0]  out_word;
    logic signed [DATA_W-1:0]  in_head;
    logic                      in_empty;
    logic                      in_pop;
    logic                      out_full;
    logic                      out_push;

    fir_stream_engine_fifo #(.W(DATA_W), .DEPTH(IN_DEPTH)) u_in_fifo (
        .clk   (CLK),
        .rst   (reset),
        .push  (req_put),
        .wdata (data_put),
        .pop   (in_pop),
        .rdata (in_head),
        .full  (full_to_bus),
        .empty (in_empty)
    );

    fir_stream_engine_fifo #(.W(DATA_W), .DEPTH(OUT_DEPTH)) u_out_fifo (
        .clk   (CLK),
        .rst   (reset),
        .push  (out_push),
        .wdata (out_word),
        .pop   (req_get_frombus),
        .rdata (data_to_bus),
        .full  (out_full),
        .empty (empty_to_bus)
    );

    assign in_pop   = (state == ST_FETCH);
    assign out_push = (state == ST_WRITE);
    assign busy     = (state != ST_IDLE);
    assign prod     = dline[idx] * coef[idx];

    // Result stage: shift, then saturate or substitute bypass/mute word
    always_comb begin
        acc_shr = acc_p1 >>> SHIFT;
        unique case (mode_p0)
            MODE_BYPASS: out_word = smp_p0;
            MODE_MUTE:   out_word = '0;
            default:     out_word = saturate(acc_shr);
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            load_pend <= 1'b0;
            idx       <= '0;
            mode_p0   <= MODE_FIR;
            smp_p0    <= '0;
            acc_p1    <= '0;
            sat_flag  <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                coef[i]  <= '0;
                dline[i] <= '0;
            end
        end else begin
            if (start_coe) begin
                load_pend <= 1'b1;
                sat_flag  <= 1'b0;
            end
            unique case (state)
                ST_IDLE: begin
                    if (start_coe || load_pend) begin
                        state     <= ST_LOAD;
                        idx       <= '0;
                        load_pend <= 1'b0;
                    end else if (!in_empty && !out_full) begin
                        state <= ST_FETCH;
                    end
                end
                ST_LOAD: begin
                    if (coe_valid) begin
                        coef[idx] <= coe_data;
                        idx       <= idx + 1'b1;
                        if (idx == LAST_IDX) state <= ST_IDLE;
                    end
                end
                // Fetch stage: pop sample, latch mode, advance delay line for FIR only
                ST_FETCH: begin
                    mode_p0 <= mode_t'(mode);
                    smp_p0  <= in_head;
                    if (mode_is_fir(mode_t'(mode))) begin
                        for (int i = TAPS - 1; i > 0; i--) dline[i] <= dline[i-1];
                        dline[0] <= in_head;
                        acc_p1   <= '0;
                        idx      <= '0;
                        state    <= ST_MAC;
                    end else begin
                        state <= ST_WRITE;
                    end
                end
                // Accumulate stage: one tap per cycle
                ST_MAC: begin
                    acc_p1 <= acc_p1 + {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
                    idx    <= idx + 1'b1;
                    if (idx == LAST_IDX) state <= ST_WRITE;
                end
                ST_WRITE: begin
                    if (mode_is_fir(mode_p0) && sat_over(acc_shr)) sat_flag <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_stream_engine.sv
// Directed bench for fir_stream_engine (TAPS=4, SHIFT=0, IN_DEPTH=4, OUT_DEPTH=2)
// with hand-computed expected outputs.
module tb_fir_stream_engine;

    logic        CLK;
    logic        reset;
    logic [15:0] data_put;
    logic        req_put;
    logic        full_to_bus;
    logic [15:0] data_to_bus;
    logic        empty_to_bus;
    logic        req_get_frombus;
    logic [1:0]  mode;
    logic        start_coe;
    logic [15:0] coe_data;
    logic        coe_valid;
    logic        busy;
    logic        sat_flag;

    int n_checks = 0;
    int n_fail   = 0;

    fir_stream_engine #(
        .DATA_W(16), .COEF_W(16), .TAPS(4), .IN_DEPTH(4), .OUT_DEPTH(2), .SHIFT(0)
    ) dut (
        .CLK             (CLK),
        .reset           (reset),
        .data_put        (data_put),
        .req_put         (req_put),
        .full_to_bus     (full_to_bus),
        .data_to_bus     (data_to_bus),
        .empty_to_bus    (empty_to_bus),
        .req_get_frombus (req_get_frombus),
        .mode            (mode),
        .start_coe       (start_coe),
        .coe_data        (coe_data),
        .coe_valid       (coe_valid),
        .busy            (busy),
        .sat_flag        (sat_flag)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_busy(input logic lvl, input string tag);
        int k;
        k = 0;
        while (busy !== lvl && k < 100) begin
            @(negedge CLK);
            k++;
        end
        check_eq({tag, "_busy"}, 32'(busy), 32'(lvl));
    endtask

    task automatic push(input logic [15:0] v);
        req_put  = 1'b1;
        data_put = v;
        @(negedge CLK);
        req_put  = 1'b0;
    endtask

    task automatic pop();
        req_get_frombus = 1'b1;
        @(negedge CLK);
        req_get_frombus = 1'b0;
    endtask

    task automatic load_coefs(input logic [15:0] c0, input logic [15:0] c1,
                              input logic [15:0] c2, input logic [15:0] c3);
        logic [15:0] c [4];
        c[0] = c0; c[1] = c1; c[2] = c2; c[3] = c3;
        start_coe = 1'b1;
        @(negedge CLK);
        start_coe = 1'b0;
        for (int i = 0; i < 4; i++) begin
            coe_valid = 1'b1;
            coe_data  = c[i];
            @(negedge CLK);
        end
        coe_valid = 1'b0;
        @(negedge CLK);
    endtask

    // Latency is counted in cycles from the engine leaving IDLE to the result at the bus.
    task automatic run_sample(input string tag, input logic [15:0] v,
                              input logic [15:0] exp, input int exp_lat);
        int n;
        push(v);
        wait_busy(1'b1, tag);
        n = 0;
        while (empty_to_bus && n < 60) begin
            @(negedge CLK);
            n++;
        end
        check_eq({tag, "_empty"}, 32'(empty_to_bus), 32'd0);
        if (exp_lat >= 0) check_eq({tag, "_lat"}, n, exp_lat);
        check_eq(tag, 32'(data_to_bus), 32'(exp));
        pop();
        wait_busy(1'b0, tag);
    endtask

    initial begin
        reset = 1'b1; data_put = '0; req_put = 1'b0; req_get_frombus = 1'b0;
        mode = 2'b00; start_coe = 1'b0; coe_data = '0; coe_valid = 1'b0;
        repeat (3) @(negedge CLK);
        reset = 1'b0;
        @(negedge CLK);
        check_eq("rst_full",  32'(full_to_bus),  32'd0);
        check_eq("rst_empty", 32'(empty_to_bus), 32'd1);
        check_eq("rst_busy",  32'(busy),         32'd0);
        check_eq("rst_sat",   32'(sat_flag),     32'd0);
        check_eq("rst_data",  32'(data_to_bus),  32'd0);

        // Impulse response
        load_coefs(16'd1, 16'd2, 16'd3, 16'd4);
        run_sample("imp0", 16'd1, 16'd1, 6);
        run_sample("imp1", 16'd0, 16'd2, -1);
        run_sample("imp2", 16'd0, 16'd3, -1);
        run_sample("imp3", 16'd0, 16'd4, -1);
        // x=[-3,0,0,0] -> -3 ; mode 11 x=[2,-3,0,0] -> 2-6=-4
        run_sample("neg",  16'hFFFD, 16'hFFFD, -1);
        mode = 2'b11;
        run_sample("fir11", 16'd2, 16'hFFFC, -1);
        check_eq("nosat", 32'(sat_flag), 32'd0);

        // Bypass / mute leave delay line alone: next FIR x=[0,2,-3,0] -> 4-9=-5
        mode = 2'b01;
        run_sample("bypass", 16'h1234, 16'h1234, 2);
        mode = 2'b10;
        run_sample("mute", 16'h1234, 16'h0000, 2);
        mode = 2'b00;
        run_sample("dline_kept", 16'd0, 16'hFFFB, 6);

        // Positive and negative saturation
        load_coefs(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        for (int i = 0; i < 4; i++) run_sample($sformatf("satp%0d", i), 16'h7FFF, 16'h7FFF, -1);
        check_eq("sat_set", 32'(sat_flag), 32'd1);
        load_coefs(16'h7FFF, 16'h0000, 16'h0000, 16'h0000);
        check_eq("sat_clr", 32'(sat_flag), 32'd0);
        run_sample("satn", 16'h8000, 16'h8000, -1);
        check_eq("sat_set2", 32'(sat_flag), 32'd1);

        // Backpressure in bypass: 2 reach output, 4 fill input, 7th dropped
        mode = 2'b01;
        for (int s = 1; s <= 7; s++) begin
            push(16'h0100 + 16'(s));
            repeat (7) @(negedge CLK);
        end
        check_eq("bp_full",  32'(full_to_bus),  32'd1);
        check_eq("bp_busy",  32'(busy),         32'd0);
        check_eq("bp_empty", 32'(empty_to_bus), 32'd0);
        check_eq("bp_head",  32'(data_to_bus),  32'h0101);
        pop();
        repeat (8) @(negedge CLK);
        check_eq("bp_resume_full", 32'(full_to_bus), 32'd0);
        for (int s = 2; s <= 6; s++) begin
            check_eq($sformatf("bp_out%0d", s), 32'(data_to_bus), 32'h0100 + s);
            pop();
            repeat (8) @(negedge CLK);
        end
        check_eq("bp_drop", 32'(empty_to_bus), 32'd1);

        // start_coe during MAC: x=[1,8000,7FFF,7FFF], coefs [7FFF,0,0,0] -> 7FFF
        mode = 2'b00;
        push(16'd1);
        wait_busy(1'b1, "rl");
        @(negedge CLK);
        start_coe = 1'b1;
        @(negedge CLK);
        start_coe = 1'b0;
        check_eq("rl_satclr", 32'(sat_flag), 32'd0);
        for (int k = 0; k < 40 && empty_to_bus; k++) @(negedge CLK);
        check_eq("rl_result", 32'(data_to_bus), 32'h7FFF);
        @(negedge CLK);
        check_eq("rl_pending", 32'(busy), 32'd1);
        for (int i = 0; i < 4; i++) begin
            coe_valid = 1'b1;
            coe_data  = 16'd1;
            @(negedge CLK);
        end
        coe_valid = 1'b0;
        @(negedge CLK);
        check_eq("rl_idle", 32'(busy), 32'd0);
        pop();
        // x=[5,1,8000,7FFF], coefs all 1 -> 5
        run_sample("rl_new", 16'd5, 16'd5, -1);

        // Reset during MAC
        push(16'd7);
        wait_busy(1'b1, "ab");
        @(negedge CLK);
        #2 reset = 1'b1;
        #1 reset = 1'b0;
        @(negedge CLK);
        check_eq("ab_full",  32'(full_to_bus),  32'd0);
        check_eq("ab_empty", 32'(empty_to_bus), 32'd1);
        check_eq("ab_busy",  32'(busy),         32'd0);
        check_eq("ab_sat",   32'(sat_flag),     32'd0);
        check_eq("ab_data",  32'(data_to_bus),  32'd0);
        run_sample("ab_coef0", 16'd9, 16'd0, 6);
        load_coefs(16'd1, 16'd1, 16'd1, 16'd1);
        run_sample("ab_dline0", 16'd0, 16'd9, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
